// File: rtl/if_stage_ibuf_pkg.sv
// Shared types and constants for the decoupled fetch stage: branch bus layout,
// ID bus width and the sequential-PC helper.
package if_stage_ibuf_pkg;

  localparam int BR_BUS_WD    = 34;
  localparam int FS_DS_BUS_WD = 64;

  // Instruction word stored in an address-error entry.
  localparam logic [31:0] ADEF_FILL_INST = 32'h0000_0000;

  // {br_stall, br_taken, br_target[31:0]}
  typedef struct packed {
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_ibuf_fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time and filled as
// responses return; the head is offered to ID once filled.
module if_fetch_queue
  import if_stage_ibuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          alloc_filled,
  input  logic          alloc_adef,
  input  logic          fill,
  input  logic [31:0]   fill_inst,
  input  logic          pop,
  output logic          head_valid,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_inst,
  output logic          head_adef,
  output logic [CW-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [PW-1:0]    fill_reg;
  logic [CW-1:0]    occ_reg;
  logic [DEPTH-1:0] filled_reg;
  logic [DEPTH-1:0] adef_reg;
  logic [DEPTH-1:0] alloc_hit;
  logic [DEPTH-1:0] fill_hit;
  logic [DEPTH-1:0] pop_hit;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dec
      assign alloc_hit[gi] = alloc & (tail_reg == PW'(gi));
      assign fill_hit[gi]  = fill  & (fill_reg == PW'(gi));
      assign pop_hit[gi]   = pop   & (head_reg == PW'(gi));
    end
  endgenerate

  // Alloc, fill and pop never target the same entry in one cycle: the full
  // check and the filled flag keep the three pointers apart.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      filled_reg <= '0;
      adef_reg   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_hit[i]) begin
          filled_reg[i] <= alloc_filled;
          adef_reg[i]   <= alloc_adef;
        end else if (fill_hit[i]) begin
          filled_reg[i] <= 1'b1;
        end else if (pop_hit[i]) begin
          filled_reg[i] <= 1'b0;
          adef_reg[i]   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_reg <= '0;
      tail_reg <= '0;
      fill_reg <= '0;
      occ_reg  <= '0;
    end else begin
      head_reg <= head_reg + PW'(pop);
      tail_reg <= tail_reg + PW'(alloc);
      fill_reg <= fill_reg + PW'(fill);
      occ_reg  <= occ_reg + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[tail_reg] <= alloc_pc;
      if (alloc_filled) begin
        inst_mem[tail_reg] <= ADEF_FILL_INST;
      end
    end
    if (fill) begin
      inst_mem[fill_reg] <= fill_inst;
    end
  end

  assign head_valid = filled_reg[head_reg];
  assign head_pc    = pc_mem[head_reg];
  assign head_inst  = inst_mem[head_reg];
  assign head_adef  = adef_reg[head_reg];
  assign occupancy  = occ_reg;

endmodule

// File: rtl/if_stage_ibuf.sv
// Decoupled IF stage with up to IBUF_DEPTH fetches in flight and redirect cancellation.
// Optional macro FS_ADEF_EN: misaligned fetch_pc produces an address-error entry and halts fetch.
module if_stage_ibuf
  import if_stage_ibuf_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h1c00_0000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BR_BUS_WD-1:0]    br_bus,
  output logic                    inst_sram_req,
  output logic [31:0]             inst_sram_addr,
  input  logic                    inst_sram_addr_ok,
  input  logic                    inst_sram_data_ok,
  input  logic [31:0]             inst_sram_rdata,
  input  logic                    ds_allow_in,
  output logic                    fs_to_ds_valid,
  output logic [FS_DS_BUS_WD-1:0] fs_ds_bus,
  output logic                    fs_adef
);

  localparam int CW = $clog2(IBUF_DEPTH) + 2;

  br_bus_t       br;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   fetch_pc_next;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] cancel_cnt_reg;
  logic [CW-1:0] cancel_cnt_next;
  logic [CW-1:0] occupancy;
  logic          occ_full;
  logic          can_issue;
  logic          accept;
  logic          data_keep;
  logic          q_alloc;
  logic          q_alloc_filled;
  logic          q_pop;
  logic          head_valid;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;
  logic          head_adef;

  assign br        = br_bus_t'(br_bus);
  assign occ_full  = (occupancy == CW'(IBUF_DEPTH));
  assign can_issue = ~reset & ~br.stall & ~br.taken & ~occ_full;
  assign data_keep = inst_sram_data_ok & (cancel_cnt_reg == '0);

`ifdef FS_ADEF_EN
  logic halt_reg;
  logic misaligned;
  logic adef_push;

  assign misaligned     = (fetch_pc_reg[1:0] != 2'b00);
  assign adef_push      = can_issue & ~halt_reg & misaligned;
  assign inst_sram_req  = can_issue & ~halt_reg & ~misaligned;
  assign q_alloc_filled = adef_push;

  // Halt holds fetch on the faulting address until software redirects.
  always_ff @(posedge clk) begin
    if (reset || br.taken) begin
      halt_reg <= 1'b0;
    end else if (adef_push) begin
      halt_reg <= 1'b1;
    end
  end
`else
  assign inst_sram_req  = can_issue;
  assign q_alloc_filled = 1'b0;
`endif

  assign accept  = inst_sram_req & inst_sram_addr_ok;
  assign q_alloc = accept | q_alloc_filled;
  assign q_pop   = head_valid & ds_allow_in & ~reset;

  // A response in the redirect cycle consumes either a pending cancel or an
  // in-flight slot, so one is subtracted in both cases.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    outstanding_next = outstanding_reg;
    cancel_cnt_next  = cancel_cnt_reg;
    if (br.taken) begin
      fetch_pc_next    = br.target;
      outstanding_next = '0;
      cancel_cnt_next  = cancel_cnt_reg + outstanding_reg - CW'(inst_sram_data_ok);
    end else begin
      if (accept) begin
        fetch_pc_next = next_seq_pc(fetch_pc_reg);
      end
      outstanding_next = outstanding_reg + CW'(accept) - CW'(data_keep);
      if (inst_sram_data_ok && !data_keep) begin
        cancel_cnt_next = cancel_cnt_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      cancel_cnt_reg  <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      cancel_cnt_reg  <= cancel_cnt_next;
    end
  end

  if_fetch_queue #(
    .DEPTH (IBUF_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .flush        (br.taken),
    .alloc        (q_alloc),
    .alloc_pc     (fetch_pc_reg),
    .alloc_filled (q_alloc_filled),
    .alloc_adef   (q_alloc_filled),
    .fill         (data_keep & ~br.taken),
    .fill_inst    (inst_sram_rdata),
    .pop          (q_pop),
    .head_valid   (head_valid),
    .head_pc      (head_pc),
    .head_inst    (head_inst),
    .head_adef    (head_adef),
    .occupancy    (occupancy)
  );

  assign inst_sram_addr = fetch_pc_reg;
  assign fs_to_ds_valid = head_valid & ~reset;
  assign fs_ds_bus      = fs_to_ds_valid ? {head_pc, head_inst} : '0;

`ifdef FS_ADEF_EN
  assign fs_adef = fs_to_ds_valid & head_adef;
`else
  assign fs_adef = 1'b0;
`endif

endmodule
